mc_ctrl_fsm: RTL and testbench

- Parametrised multi-cycle control FSM for the ARM-subset datapath; next generation of the core sequencer.
- Drives PC/IR/register-file write enables, A/B/C/F latches, datapath muxes and ALU/shifter control.
- Adds over the previous sequencer:
  - instruction-level condition skip;
  - LDR/STR with a req/ready memory handshake;
  - BL decoded from the live IR;
  - parametrised op-field widths and ALU codes.
- Sits between the IR/decoder and the datapath/data-memory port.

---
 rtl/mc_ctrl_pkg.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 259 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and decode constants for the multi-cycle control sequencer.
// StFault exists only when MC_CTRL_MEM_TIMEOUT_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExec    = 4'd3,
    StWb      = 4'd4,
    StBxPc    = 4'd5,
    StBCalc   = 4'd6,
    StBlLink  = 4'd7,
    StBlCalc  = 4'd8,
    StPcLoad  = 4'd9,
    StMemAddr = 4'd10,
    StMemAcc  = 4'd11,
    StMemWb   = 4'd12
`ifdef MC_CTRL_MEM_TIMEOUT_EN
    ,
    StFault   = 4'd13
`endif
  } state_e;

  // PC source mux codes
  localparam logic [1:0] PcSrcPlus4 = 2'b00;
  localparam logic [1:0] PcSrcB     = 2'b01;
  localparam logic [1:0] PcSrcF     = 2'b10;

  // Instruction class fields
  localparam logic [3:0]  OpB       = 4'b1010;
  localparam logic [3:0]  OpBl      = 4'b1011;
  localparam logic [23:0] BxPattern = 24'h12FFF1;
  localparam logic [1:0]  MemClass  = 2'b01;
  localparam int unsigned LoadBit   = 20;

endpackage

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences PC/IR/regfile writes, latches, muxes and ALU control.
// Optional memory-access timeout with sticky FAULT state: define MC_CTRL_MEM_TIMEOUT_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned          ALU_OP_W   = 4,
  parameter int unsigned          SHIFT_OP_W = 3,
  parameter logic [ALU_OP_W-1:0]  ALU_ADD    = 4'b0100,
  parameter logic [ALU_OP_W-1:0]  ALU_PASS_A = 4'b1000
`ifdef MC_CTRL_MEM_TIMEOUT_EN
  ,
  parameter int unsigned          TMO_W      = 8
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           ir,
  input  logic                  ir_valid,
  input  logic                  cond_pass,
  input  logic                  rm_imm_s,
  input  logic [1:0]            rs_imm_s,
  input  logic [SHIFT_OP_W-1:0] shift_op,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic                  s_bit,
  input  logic                  mem_ready,
  output logic                  write_pc,
  output logic                  write_ir,
  output logic                  write_reg,
  output logic                  la,
  output logic                  lb,
  output logic                  lc,
  output logic                  lf,
  output logic [1:0]            pc_s,
  output logic                  alu_a_s,
  output logic                  alu_b_s,
  output logic                  rd_s,
  output logic                  wb_s,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  s_ctrl,
  output logic                  rm_imm_s_ctrl,
  output logic [1:0]            rs_imm_s_ctrl,
  output logic [SHIFT_OP_W-1:0] shift_op_ctrl,
  output logic [ALU_OP_W-1:0]   alu_op_ctrl,
`ifdef MC_CTRL_MEM_TIMEOUT_EN
  output logic                  fault,
`endif
  output logic [3:0]            state
);

  state_e state_q, state_d;

  logic                  s_q, s_d;
  logic                  rm_q, rm_d;
  logic [1:0]            rs_q, rs_d;
  logic [SHIFT_OP_W-1:0] sh_q, sh_d;
  logic [ALU_OP_W-1:0]   aop_q, aop_d;

  logic is_b, is_bl, is_bx, is_mem, is_load;

  assign is_b    = (ir[27:24] == OpB);
  assign is_bl   = (ir[27:24] == OpBl);
  assign is_bx   = (ir[27:4] == BxPattern);
  assign is_mem  = (ir[27:26] == MemClass);
  assign is_load = ir[LoadBit];

  // Condition code and Rm field are consumed elsewhere in the datapath.
  logic unused_ir;
  assign unused_ir = ^{ir[31:28], ir[3:0]};

`ifdef MC_CTRL_MEM_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StMemAddr) begin
      tmo_d = '0;
    end else if (state_q == StMemAcc && !mem_ready) begin
      tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
    end
  end

  assign tmo_hit = &tmo_d;
  assign fault   = (state_q == StFault);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    state_d = StFetch;
      StFetch: begin
        // A valid instruction failing its condition retires here as a NOP.
        if (ir_valid && cond_pass) begin
          if (is_b) begin
            state_d = StBCalc;
          end else if (is_bl) begin
            state_d = StBlLink;
          end else begin
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        if (is_bx) begin
          state_d = StBxPc;
        end else if (is_mem) begin
          state_d = StMemAddr;
        end else begin
          state_d = StExec;
        end
      end
      StExec:    state_d = StWb;
      StWb:      state_d = StFetch;
      StBxPc:    state_d = StFetch;
      StBCalc:   state_d = StPcLoad;
      StBlLink:  state_d = StBlCalc;
      StBlCalc:  state_d = StPcLoad;
      StPcLoad:  state_d = StFetch;
      StMemAddr: state_d = StMemAcc;
      StMemAcc: begin
        if (mem_ready) begin
          state_d = is_load ? StMemWb : StFetch;
        end
`ifdef MC_CTRL_MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = StFault;
        end
`endif
      end
      StMemWb:   state_d = StFetch;
`ifdef MC_CTRL_MEM_TIMEOUT_EN
      StFault:   state_d = StFault;
`endif
      default:   state_d = StFetch;
    endcase
  end

  // Decoder fields are sampled on the single DECODE cycle and held afterwards.
  always_comb begin
    s_d   = s_q;
    rm_d  = rm_q;
    rs_d  = rs_q;
    sh_d  = sh_q;
    aop_d = aop_q;
    if (state_q == StDecode) begin
      s_d   = s_bit;
      rm_d  = rm_imm_s;
      rs_d  = rs_imm_s;
      sh_d  = shift_op;
      aop_d = alu_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      s_q     <= 1'b0;
      rm_q    <= 1'b0;
      rs_q    <= '0;
      sh_q    <= '0;
      aop_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rm_q    <= rm_d;
      rs_q    <= rs_d;
      sh_q    <= sh_d;
      aop_q   <= aop_d;
    end
  end

  always_comb begin
    write_pc      = 1'b0;
    write_ir      = 1'b0;
    write_reg     = 1'b0;
    la            = 1'b0;
    lb            = 1'b0;
    lc            = 1'b0;
    lf            = 1'b0;
    pc_s          = PcSrcPlus4;
    alu_a_s       = 1'b0;
    alu_b_s       = 1'b0;
    rd_s          = 1'b0;
    wb_s          = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    s_ctrl        = s_q;
    rm_imm_s_ctrl = rm_q;
    rs_imm_s_ctrl = rs_q;
    shift_op_ctrl = sh_q;
    alu_op_ctrl   = aop_q;
    case (state_q)
      StFetch: begin
        write_pc = ir_valid;
        write_ir = ir_valid;
      end
      StDecode: begin
        la = 1'b1;
        lb = 1'b1;
        lc = 1'b1;
      end
      StExec:  lf = 1'b1;
      StWb:    write_reg = 1'b1;
      StBxPc: begin
        write_pc = 1'b1;
        pc_s     = PcSrcB;
      end
      StBCalc: begin
        alu_a_s     = 1'b1;
        alu_b_s     = 1'b1;
        alu_op_ctrl = ALU_ADD;
        s_ctrl      = 1'b0;
        lf          = 1'b1;
      end
      StBlLink: begin
        alu_a_s     = 1'b1;
        alu_op_ctrl = ALU_PASS_A;
        s_ctrl      = 1'b0;
        lf          = 1'b1;
      end
      StBlCalc: begin
        // Old F (return address) goes to R14 while F is reloaded with the target.
        write_reg   = 1'b1;
        rd_s        = 1'b1;
        alu_a_s     = 1'b1;
        alu_b_s     = 1'b1;
        alu_op_ctrl = ALU_ADD;
        s_ctrl      = 1'b0;
        lf          = 1'b1;
      end
      StPcLoad: begin
        write_pc = 1'b1;
        pc_s     = PcSrcF;
      end
      StMemAddr: lf = 1'b1;
      StMemAcc: begin
        mem_req = 1'b1;
        mem_we  = !is_load;
      end
      StMemWb: begin
        write_reg = 1'b1;
        wb_s      = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm (default build, timeout feature off).
module tb_mc_ctrl_fsm;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3;
  localparam logic [3:0] S_WB = 4'd4, S_BXPC = 4'd5, S_BCALC = 4'd6, S_BLLINK = 4'd7;
  localparam logic [3:0] S_BLCALC = 4'd8, S_PCLOAD = 4'd9, S_MEMADDR = 4'd10;
  localparam logic [3:0] S_MEMACC = 4'd11, S_MEMWB = 4'd12;

  // Strobe bit positions: {wpc,wir,wreg,la,lb,lc,lf,pc_s[1:0],aas,abs,rds,wbs,mreq,mwe}
  localparam logic [14:0] W_PC = 15'h4000, W_IR = 15'h2000, W_REG = 15'h1000;
  localparam logic [14:0] L_A = 15'h0800, L_B = 15'h0400, L_C = 15'h0200, L_F = 15'h0100;
  localparam logic [14:0] PCS_F = 15'h0080, PCS_B = 15'h0040, A_S = 15'h0020, B_S = 15'h0010;
  localparam logic [14:0] RD_S = 15'h0008, WB_S = 15'h0004, M_REQ = 15'h0002, M_WE = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;

  // Control fields: {s, rm, rs[1:0], sh[2:0], aop[3:0]}
  localparam logic [10:0] C0   = 11'h000;
  localparam logic [10:0] C1   = {1'b1, 1'b1, 2'b10, 3'b101, 4'hA};
  localparam logic [10:0] C1_B = {1'b0, 1'b1, 2'b10, 3'b101, 4'b0100};
  localparam logic [10:0] C1_L = {1'b0, 1'b1, 2'b10, 3'b101, 4'b1000};
  localparam logic [10:0] C2   = {1'b0, 1'b0, 2'b01, 3'b010, 4'h3};
  localparam logic [10:0] C3   = {1'b0, 1'b1, 2'b00, 3'b000, 4'h4};

  localparam logic [31:0] I_ADD = 32'hE0810002, I_B = 32'hEA000004, I_BL = 32'hEB000010;
  localparam logic [31:0] I_BX = 32'hE12FFF11, I_LDR = 32'hE5912000, I_STR = 32'hE5812000;

  typedef struct packed {
    logic [31:0] ir;
    logic        iv;
    logic        cp;
    logic        mr;
    logic [10:0] dec;
    logic [29:0] exp;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] ir;
  logic        ir_valid, cond_pass, rm_imm_s, s_bit, mem_ready;
  logic [1:0]  rs_imm_s;
  logic [2:0]  shift_op;
  logic [3:0]  alu_op;
  logic        write_pc, write_ir, write_reg, la, lb, lc, lf, alu_a_s, alu_b_s, rd_s, wb_s;
  logic        mem_req, mem_we, s_ctrl, rm_imm_s_ctrl;
  logic [1:0]  pc_s, rs_imm_s_ctrl;
  logic [2:0]  shift_op_ctrl;
  logic [3:0]  alu_op_ctrl, state;
  logic [29:0] act;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [0:30];

  assign act = {state, write_pc, write_ir, write_reg, la, lb, lc, lf, pc_s, alu_a_s, alu_b_s,
                rd_s, wb_s, mem_req, mem_we, s_ctrl, rm_imm_s_ctrl, rs_imm_s_ctrl,
                shift_op_ctrl, alu_op_ctrl};

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ir_valid(ir_valid), .cond_pass(cond_pass),
    .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .shift_op(shift_op), .alu_op(alu_op),
    .s_bit(s_bit), .mem_ready(mem_ready), .write_pc(write_pc), .write_ir(write_ir),
    .write_reg(write_reg), .la(la), .lb(lb), .lc(lc), .lf(lf), .pc_s(pc_s),
    .alu_a_s(alu_a_s), .alu_b_s(alu_b_s), .rd_s(rd_s), .wb_s(wb_s), .mem_req(mem_req),
    .mem_we(mem_we), .s_ctrl(s_ctrl), .rm_imm_s_ctrl(rm_imm_s_ctrl),
    .rs_imm_s_ctrl(rs_imm_s_ctrl), .shift_op_ctrl(shift_op_ctrl),
    .alu_op_ctrl(alu_op_ctrl), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] e(input logic [3:0] st, input logic [14:0] stb,
                                    input logic [10:0] ctl);
    return {st, stb, ctl};
  endfunction

  function automatic vec_t v(input logic [31:0] i, input logic iv, input logic cp,
                             input logic mr, input logic [10:0] dec, input logic [29:0] ex);
    vec_t r;
    r.ir = i; r.iv = iv; r.cp = cp; r.mr = mr; r.dec = dec; r.exp = ex;
    return r;
  endfunction

  task automatic drive(input logic [31:0] i, input logic iv, input logic cp, input logic mr,
                       input logic [10:0] dec);
    ir = i; ir_valid = iv; cond_pass = cp; mem_ready = mr;
    {s_bit, rm_imm_s, rs_imm_s, shift_op, alu_op} = dec;
  endtask

  task automatic check(input string name, input logic [29:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got st=%0d stb=%h ctl=%h, want st=%0d stb=%h ctl=%h", name,
               act[29:26], act[25:11], act[10:0], ex[29:26], ex[25:11], ex[10:0]);
    end
  endtask

  initial begin
    // DP ADD
    vecs[0]  = v(I_ADD, 0, 1, 0, C0, e(S_IDLE, NONE, C0));
    vecs[1]  = v(I_ADD, 0, 1, 0, C0, e(S_FETCH, NONE, C0));
    vecs[2]  = v(I_ADD, 1, 1, 0, C0, e(S_FETCH, W_PC | W_IR, C0));
    vecs[3]  = v(I_ADD, 0, 1, 0, C1, e(S_DECODE, L_A | L_B | L_C, C0));
    vecs[4]  = v(I_ADD, 0, 1, 0, C0, e(S_EXEC, L_F, C1));
    vecs[5]  = v(I_ADD, 0, 1, 0, C0, e(S_WB, W_REG, C1));
    // B
    vecs[6]  = v(I_B, 1, 1, 0, C0, e(S_FETCH, W_PC | W_IR, C1));
    vecs[7]  = v(I_B, 0, 1, 0, C0, e(S_BCALC, L_F | A_S | B_S, C1_B));
    vecs[8]  = v(I_B, 0, 1, 0, C0, e(S_PCLOAD, W_PC | PCS_F, C1));
    // BL
    vecs[9]  = v(I_BL, 1, 1, 0, C0, e(S_FETCH, W_PC | W_IR, C1));
    vecs[10] = v(I_BL, 0, 1, 0, C0, e(S_BLLINK, L_F | A_S, C1_L));
    vecs[11] = v(I_BL, 0, 1, 0, C0, e(S_BLCALC, W_REG | RD_S | L_F | A_S | B_S, C1_B));
    vecs[12] = v(I_BL, 0, 1, 0, C0, e(S_PCLOAD, W_PC | PCS_F, C1));
    // BX
    vecs[13] = v(I_BX, 1, 1, 0, C0, e(S_FETCH, W_PC | W_IR, C1));
    vecs[14] = v(I_BX, 0, 1, 0, C2, e(S_DECODE, L_A | L_B | L_C, C1));
    vecs[15] = v(I_BX, 0, 1, 0, C0, e(S_BXPC, W_PC | PCS_B, C2));
    // LDR with three wait cycles
    vecs[16] = v(I_LDR, 1, 1, 0, C0, e(S_FETCH, W_PC | W_IR, C2));
    vecs[17] = v(I_LDR, 0, 1, 0, C3, e(S_DECODE, L_A | L_B | L_C, C2));
    vecs[18] = v(I_LDR, 0, 1, 0, C0, e(S_MEMADDR, L_F, C3));
    vecs[19] = v(I_LDR, 0, 1, 0, C0, e(S_MEMACC, M_REQ, C3));
    vecs[20] = v(I_LDR, 0, 1, 0, C0, e(S_MEMACC, M_REQ, C3));
    vecs[21] = v(I_LDR, 0, 1, 0, C0, e(S_MEMACC, M_REQ, C3));
    vecs[22] = v(I_LDR, 0, 1, 1, C0, e(S_MEMACC, M_REQ, C3));
    vecs[23] = v(I_LDR, 0, 1, 1, C0, e(S_MEMWB, W_REG | WB_S, C3));
    // STR, mem_ready held high outside MEM_ACC has no effect
    vecs[24] = v(I_STR, 1, 1, 1, C0, e(S_FETCH, W_PC | W_IR, C3));
    vecs[25] = v(I_STR, 0, 1, 1, C3, e(S_DECODE, L_A | L_B | L_C, C3));
    vecs[26] = v(I_STR, 0, 1, 1, C0, e(S_MEMADDR, L_F, C3));
    vecs[27] = v(I_STR, 0, 1, 1, C0, e(S_MEMACC, M_REQ | M_WE, C3));
    // Condition fail: NOP, stays in FETCH
    vecs[28] = v(I_ADD, 1, 0, 0, C1, e(S_FETCH, W_PC | W_IR, C3));
    vecs[29] = v(I_ADD, 1, 0, 0, C1, e(S_FETCH, W_PC | W_IR, C3));
    vecs[30] = v(I_ADD, 0, 0, 0, C1, e(S_FETCH, NONE, C3));

    rst_n = 1'b1;
    drive(32'h0, 0, 0, 0, C0);
    #1 rst_n = 1'b0;
    #2 check("reset_async", e(S_IDLE, NONE, C0));
    repeat (2) @(posedge clk);
    #1 check("reset_held", e(S_IDLE, NONE, C0));
    rst_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].ir, vecs[i].iv, vecs[i].cp, vecs[i].mr, vecs[i].dec);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Async reset in the middle of a load access
    drive(I_LDR, 1, 1, 0, C3);
    repeat (3) begin
      @(posedge clk);
      #1 ir_valid = 1'b0;
    end
    @(negedge clk);
    check("pre_abort_memacc", e(S_MEMACC, M_REQ, C3));
    #2 rst_n = 1'b0;
    #1 check("abort_async", e(S_IDLE, NONE, C0));
    @(posedge clk);
    #1 check("abort_held", e(S_IDLE, NONE, C0));
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_idle", e(S_IDLE, NONE, C0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("restart_fetch", e(S_FETCH, NONE, C0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
